// File: rtl/dds_phase_gen_pkg.sv
// Shared defaults for the DDS phase generator: datapath widths, ROM latency
// and the DAC idle code.
package dds_phase_gen_pkg;

    localparam int DDS_ACC_WIDTH   = 32;
    localparam int DDS_ADDR_WIDTH  = 10;
    localparam int DDS_DATA_WIDTH  = 8;
    localparam int DDS_ROM_LATENCY = 1;

    // Idle output code: the middle of the DAC range, i.e. zero volts on a bipolar output.
    localparam logic [DDS_DATA_WIDTH-1:0] DDS_DAC_MIDSCALE = 8'h80;

    // Midscale code for an arbitrary DAC width (only the MSB set).
    function automatic logic [31:0] dds_midscale(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/dds_valid_pipe.sv
// Valid-token delay line. Each token is marked with the cycle in which its ROM
// address was registered, and it comes out DEPTH cycles later, when the
// matching ROM data is ready. It keeps shifting while the run is disabled, so
// samples already in flight drain out. DEPTH must be at least 2.
module dds_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    logic [DEPTH-1:0] stages;

    // Shift the token chain one stage every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], in};
        end
    end

    assign out = stages[DEPTH-1];

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase generator. A phase accumulator drives the address of an external
// waveform ROM. The ROM output is registered towards the DAC once the ROM
// latency has elapsed. New tuning words are held in shadow registers and take
// effect at a phase wrap, so each waveform period ends cleanly.
module dds_phase_gen
    import dds_phase_gen_pkg::*;
#(
    parameter int ACC_WIDTH   = DDS_ACC_WIDTH,
    parameter int ADDR_WIDTH  = DDS_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DDS_DATA_WIDTH,
    parameter int ROM_LATENCY = DDS_ROM_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ACC_WIDTH-1:0]  ftw_in,
    input  logic [ADDR_WIDTH-1:0] pow_in,
    input  logic                  cfg_load,
    output logic                  cfg_ack,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_valid,
    output logic                  cycle_start
);

    localparam logic [DATA_WIDTH-1:0] MIDSCALE = DATA_WIDTH'(dds_midscale(DATA_WIDTH));

    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  ftw_act;
    logic [ACC_WIDTH-1:0]  ftw_shadow;
    logic [ADDR_WIDTH-1:0] pow_act;
    logic [ADDR_WIDTH-1:0] pow_shadow;
    logic                  pending;
    logic [ACC_WIDTH:0]    acc_sum;
    logic                  carry;
    logic                  apply_cfg;
    logic                  sample_due;

    // Accumulator sum with its carry-out; the carry marks the end of a waveform period.
    always_comb begin
        acc_sum   = {1'b0, acc} + {1'b0, ftw_act};
        carry     = acc_sum[ACC_WIDTH];
        apply_cfg = pending & (en ? carry : 1'b1);
    end

    // Advance the phase and register the ROM address from the pre-update phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            rom_addr    <= '0;
            cycle_start <= 1'b0;
        end else begin
            cycle_start <= en & carry;
            if (en) begin
                acc      <= acc_sum[ACC_WIDTH-1:0];
                rom_addr <= acc[ACC_WIDTH-1 -: ADDR_WIDTH] + pow_act;
            end
        end
    end

    // Shadow config capture and apply. A load on the apply edge is captured after the apply, so it stays pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ftw_act    <= '0;
            pow_act    <= '0;
            ftw_shadow <= '0;
            pow_shadow <= '0;
            pending    <= 1'b0;
            cfg_ack    <= 1'b0;
        end else begin
            cfg_ack <= apply_cfg;
            if (apply_cfg) begin
                ftw_act <= ftw_shadow;
                pow_act <= pow_shadow;
                pending <= 1'b0;
            end
            if (cfg_load) begin
                ftw_shadow <= ftw_in;
                pow_shadow <= pow_in;
                pending    <= 1'b1;
            end
        end
    end

    dds_valid_pipe #(
        .DEPTH (ROM_LATENCY + 1)
    ) u_valid_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (en),
        .out   (sample_due)
    );

    // Capture ROM data when its token arrives; otherwise hold the last sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dac_data  <= MIDSCALE;
            dac_valid <= 1'b0;
        end else begin
            dac_valid <= sample_due;
            if (sample_due) begin
                dac_data <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen. A 1-cycle identity ROM sits on the
// DUT's ROM port. Every cycle is compared against a behavioural model of
// phase, address and config hand-off, using directed scenarios followed by
// random traffic.
module tb_dds_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cfg_load;
    logic [31:0] ftw_in;
    logic [9:0]  pow_in;
    logic        cfg_ack;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  dac_data;
    logic        dac_valid;
    logic        cycle_start;

    int check_count = 0;
    int fail_count  = 0;
    int cyc         = 0;

    // Model state
    longint unsigned m_acc, m_ftw, m_sh_ftw;
    int  m_pow, m_sh_pow, m_addr, m_data;
    bit  m_pending, m_cs, m_ack, m_valid;

    typedef struct {
        int due;
        int data;
    } sample_t;
    sample_t pend_q[$];

    // Observed event counters for per-scenario checks
    int obs_cs, obs_ack, addr_changes;
    logic [9:0] last_addr;

    always #5 clk = ~clk;

    dds_phase_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ftw_in      (ftw_in),
        .pow_in      (pow_in),
        .cfg_load    (cfg_load),
        .cfg_ack     (cfg_ack),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .dac_data    (dac_data),
        .dac_valid   (dac_valid),
        .cycle_start (cycle_start)
    );

    // Waveform ROM: the sample is the low byte of the address, one cycle after the address.
    always @(posedge clk) rom_data <= rom_addr[7:0];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_acc = 0; m_ftw = 0; m_sh_ftw = 0;
        m_pow = 0; m_sh_pow = 0; m_addr = 0; m_data = 8'h80;
        m_pending = 0; m_cs = 0; m_ack = 0; m_valid = 0;
        pend_q.delete();
    endtask

    // One clock edge of the reference behaviour, driven by the inputs seen at that edge.
    task automatic modelEdge(input logic r, input logic e, input logic l,
                             input logic [31:0] f, input logic [9:0] p);
        longint unsigned sum;
        bit wrap, apply;
        sample_t s;
        if (!r) begin
            modelReset();
            return;
        end
        sum  = m_acc + m_ftw;
        wrap = e && (sum >= 64'h1_0000_0000);
        if (e) begin
            m_addr = int'(((m_acc >> 22) + longint'(m_pow)) % 1024);
            s.due  = cyc + 2;
            s.data = m_addr % 256;
            pend_q.push_back(s);
            m_acc  = sum % 64'h1_0000_0000;
        end
        m_cs  = wrap;
        apply = m_pending && (!e || wrap);
        m_ack = apply;
        if (apply) begin
            m_ftw     = m_sh_ftw;
            m_pow     = m_sh_pow;
            m_pending = 0;
        end
        if (l) begin
            m_sh_ftw  = longint'(f);
            m_sh_pow  = int'(p);
            m_pending = 1;
        end
        m_valid = 0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            m_data  = pend_q[0].data;
            m_valid = 1;
            void'(pend_q.pop_front());
        end
    endtask

    task automatic compareAll();
        checkOutput("rom_addr", 64'(rom_addr), 64'(m_addr));
        checkOutput("dac_data", 64'(dac_data), 64'(m_data));
        checkOutput("dac_valid", 64'(dac_valid), 64'(m_valid));
        checkOutput("cycle_start", 64'(cycle_start), 64'(m_cs));
        checkOutput("cfg_ack", 64'(cfg_ack), 64'(m_ack));
        obs_cs  += int'(cycle_start);
        obs_ack += int'(cfg_ack);
        if (rom_addr !== last_addr) addr_changes++;
        last_addr = rom_addr;
    endtask

    task automatic clearCounters();
        obs_cs = 0; obs_ack = 0; addr_changes = 0; last_addr = rom_addr;
    endtask

    // Drive inputs on the falling edge, step the model on the rising edge, compare just after.
    task automatic applyStimulus(input logic r, input logic e, input logic l,
                                 input logic [31:0] f, input logic [9:0] p);
        @(negedge clk);
        rst_n = r; en = e; cfg_load = l; ftw_in = f; pow_in = p;
        @(posedge clk);
        cyc++;
        modelEdge(r, e, l, f, p);
        #1;
        compareAll();
    endtask

    task automatic runCycles(input int n, input logic e);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, e, 1'b0, 32'd0, 10'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; ftw_in = '0; pow_in = '0;
        modelReset();
        last_addr = '0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 10'h3FF);
        checkOutput("reset_dac_midscale", 64'(dac_data), 64'h80);

        $display("[TB] scenario 1: ftw=2^22 sweep");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0000, 10'd0);
        runCycles(1, 1'b0);
        clearCounters();
        runCycles(2048, 1'b1);
        checkOutput("s1_cycle_starts", 64'(obs_cs), 64'd2);

        $display("[TB] scenario 2: retune at address 300");
        for (int i = 0; i < 1100 && m_addr != 300; i++) runCycles(1, 1'b1);
        clearCounters();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0080_0000, 10'd512);
        runCycles(1024, 1'b1);
        checkOutput("s2_acks", 64'(obs_ack), 64'd1);

        $display("[TB] scenario 3: enable gap");
        runCycles(10, 1'b0);
        runCycles(20, 1'b1);

        $display("[TB] scenario 4: double load");
        clearCounters();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0020_0000, 10'd0);
        runCycles(4, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0100_0000, 10'd0);
        runCycles(600, 1'b1);
        checkOutput("s4_acks", 64'(obs_ack), 64'd1);

        $display("[TB] scenario 5: reset with pending config");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234_5678, 10'd77);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 10'd0);
        checkOutput("s5_dac_midscale", 64'(dac_data), 64'h80);
        clearCounters();
        runCycles(5, 1'b0);
        checkOutput("s5_acks", 64'(obs_ack), 64'd0);

        $display("[TB] scenario 6: zero tuning word");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_3039, 10'd5);
        runCycles(300, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd0, 10'd5);
        runCycles(1, 1'b0);
        runCycles(2, 1'b1);
        clearCounters();
        runCycles(2000, 1'b1);
        checkOutput("s6_cycle_starts", 64'(obs_cs), 64'd0);
        checkOutput("s6_addr_changes", 64'(addr_changes), 64'd0);

        $display("[TB] scenario 7: random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 500) != 0, ($urandom % 8) != 0, ($urandom % 64) == 0,
                          32'($urandom), 10'($urandom % 1024));
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/dds_phase_gen.md
DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

Interface
REQ-001 SHALL have parameters: ACC_WIDTH, default 32, phase accumulator width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, waveform ROM address width; ADDR_WIDTH < ACC_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, ROM sample and DAC code width.
REQ-004 SHALL have parameter ROM_LATENCY, default 1, cycles from rom_addr registered to rom_data valid; legal 1..4.
REQ-005 SHALL have ports, one clock and synchronous active-low reset:
- clk in 1: sole clock, all logic rising-edge.
- rst_n in 1: synchronous active-low reset.
- en in 1: run enable.
- ftw_in in ACC_WIDTH: frequency tuning word.
- pow_in in ADDR_WIDTH: phase offset word.
- cfg_load in 1: single-cycle strobe capturing ftw_in/pow_in.
- cfg_ack out 1: one-cycle pulse when the captured config takes effect.
- rom_addr out ADDR_WIDTH: registered address to waveform ROM.
- rom_data in DATA_WIDTH: ROM read data.
- dac_data out DATA_WIDTH: registered sample to AD9708 driver.
- dac_valid out 1: dac_data holds a fresh sample this cycle.
- cycle_start out 1: one-cycle pulse on accumulator wrap.

Function
REQ-006 On each edge with en=1: acc <= acc + ftw_act, modulo 2^ACC_WIDTH; en=0: acc holds.
REQ-007 On each edge with en=1: rom_addr <= acc[ACC_WIDTH-1 -: ADDR_WIDTH] + pow_act, modulo 2^ADDR_WIDTH (the pre-update acc); en=0: rom_addr holds.
REQ-008 A valid token SHALL enter a ROM_LATENCY+1 stage shift register whenever rom_addr is loaded (en=1).
REQ-009 On the final stage, dac_data <= rom_data and dac_valid=1; otherwise dac_data holds and dac_valid=0.
REQ-010 With ROM_LATENCY=1, first dac_valid SHALL be 3 cycles after the first enabled edge, then every cycle while en=1.
REQ-011 Deasserting en SHALL drain in-flight tokens; dac_valid falls 3 cycles (ROM_LATENCY=1) after the last enabled edge.
REQ-012 cycle_start SHALL pulse in the cycle after an enabled edge whose addition produced a carry-out.
REQ-013 cfg_load=1 SHALL copy ftw_in/pow_in into shadow registers and set pending.
- A later cfg_load while pending overwrites the shadow; last write wins.
REQ-014 While pending and en=1: at the edge producing carry-out, ftw_act/pow_act <= shadow, pending cleared, cfg_ack pulses next cycle.
- That edge's own add SHALL use the old ftw_act.
REQ-015 While pending and en=0: the shadow SHALL be applied on the next edge, with cfg_ack pulsing.
REQ-016 cfg_load coinciding with an apply edge SHALL apply the old shadow, then capture the new values and leave pending=1.
REQ-017 ftw_act=0 with en=1 SHALL hold a constant address with dac_valid high; no cycle_start.

Reset
REQ-018 On rst_n=0 at an edge, the following SHALL be set:
- acc, ftw_act, pow_act, shadows, pending: 0.
- rom_addr: 0.
- valid pipe, dac_valid, cfg_ack, cycle_start: 0.
- dac_data: 2^(DATA_WIDTH-1) (0x80, DAC midscale).
REQ-019 Reset SHALL override en and cfg_load in the same cycle; reset mid-run discards pending config and in-flight samples.

Structure
REQ-020 Shared package SHALL hold default widths (ACC 32, ADDR 10, DATA 8), DAC midscale constant, ROM_LATENCY default.
REQ-021 The valid delay line SHALL be one sub-module, dds_valid_pipe (parameter depth, clk/rst_n/in/out).
REQ-022 The ROM itself is external; this block SHALL contain no memory.

Verification
REQ-023 Bench SHALL model ROM as addr-to-data identity (low 8 bits) with 1-cycle latency and cover the following scenarios.
- ftw_act=2^22, pow=0, en=1: rom_addr steps 0,1,2..1023,0; dac_data 0,1,2..255,0..; cycle_start every 1024 cycles.
- cfg_load ftw=2^23, pow=512 at address 300 while running: no change until wrap; cfg_ack one cycle after carry edge; then addresses 512,514,516...
- en low for 10 cycles mid-run: rom_addr and dac_data frozen; dac_valid drops 3 cycles after last enabled edge; resumes without skipped address.
- Two cfg_loads (ftw=2^21, then 2^24) before a wrap: only 2^24 applied; single cfg_ack.
- rst_n low for one cycle mid-run with pending config: next cycle all outputs at reset values, dac_data=0x80; no cfg_ack afterwards.
- ftw=0 loaded with en=0: cfg_ack next cycle; en=1: rom_addr constant, no cycle_start over 2000 cycles.
